// File: rtl/axi_sram_responder_pkg.sv
// Shared AXI4 widths and burst encoding for the SRAM responder slice.
package axi_sram_responder_pkg;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_type_t;
endpackage

// File: rtl/axi_sram_responder_if.sv
// AXI4 bus subset (no IDs, RESP or RLAST): m_* driven by the master, s_* by the slave.
interface axi4_interface;
  import axi_sram_responder_pkg::*;

  logic                      m_awvalid;
  logic [AXI_ADDR_WIDTH-1:0] m_awaddr;
  logic [7:0]                m_awlen;
  logic [2:0]                m_awsize;
  axi_burst_type_t           m_awburst;
  logic [3:0]                m_awcache;
  logic                      s_awready;

  logic                      m_wvalid;
  logic [AXI_DATA_WIDTH-1:0] m_wdata;
  logic [AXI_STRB_WIDTH-1:0] m_wstrb;
  logic                      m_wlast;
  logic                      s_wready;

  logic                      s_bvalid;
  logic                      m_bready;

  logic                      m_arvalid;
  logic [AXI_ADDR_WIDTH-1:0] m_araddr;
  logic [7:0]                m_arlen;
  logic [2:0]                m_arsize;
  axi_burst_type_t           m_arburst;
  logic [3:0]                m_arcache;
  logic                      s_arready;

  logic                      s_rvalid;
  logic [AXI_DATA_WIDTH-1:0] s_rdata;
  logic                      m_rready;

  modport master (
    output m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awcache,
    output m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
    output m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arcache, m_rready,
    input  s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata
  );

  modport slave (
    input  m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awcache,
    input  m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
    input  m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arcache, m_rready,
    output s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata
  );
endinterface

// File: rtl/axi_sram_responder_sram.sv
// Single-port SRAM with per-byte write enables and a registered read port.
module sram_1r1w_be #(
  parameter  int DEPTH = 4096,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int NB    = WIDTH / 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [NB-1:0]    be_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [NB-1:0][7:0] mem_q [DEPTH];
  logic [WIDTH-1:0]   rdata_q;

  // Read register only loads on re_i, so data holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem_q[addr_i][b] <= wdata_i[b*8 +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_sram_responder.sv
// AXI4 slave backed by one SRAM; one burst at a time, one beat per cycle.
// Define AXI_SRAM_STALL_EN to add LFSR-driven random ready stalls.
module axi_sram_responder
  import axi_sram_responder_pkg::*;
#(
  parameter int          MEM_WORDS  = 4096,
  parameter logic [15:0] STALL_SEED = 16'hace1
) (
  input logic           clk,
  input logic           reset_n,
  axi4_interface.slave  axi_bus
);
  localparam int OFS  = $clog2(AXI_DATA_WIDTH / 8);
  localparam int IDXW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WRITE_BURST, WRITE_RESP, READ_BURST} state_e;
  typedef enum logic {RR_WRITE, RR_READ} rr_e;

  state_e          state_q, state_d;
  rr_e             rr_q, rr_d;
  logic [IDXW-1:0] idx_q, idx_d, idx_nxt;
  logic [7:0]      cnt_q, cnt_d, len_q, len_d;
  axi_burst_type_t burst_q, burst_d;

  logic stall, rdy_ok, both, last;
  logic aw_rdy, ar_rdy, w_rdy;
  logic mem_we, mem_re;
  logic [IDXW-1:0]           mem_addr;
  logic [AXI_DATA_WIDTH-1:0] mem_q;

`ifdef AXI_SRAM_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk) begin
    if (!reset_n) lfsr_q <= STALL_SEED;
    else          lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // Inputs this responder deliberately ignores (size, cache, upper address bits).
  logic unused_cfg;
  assign unused_cfg = ^{STALL_SEED, axi_bus.m_awsize, axi_bus.m_arsize, axi_bus.m_awcache,
                        axi_bus.m_arcache, axi_bus.m_awaddr, axi_bus.m_araddr};

  assign both    = axi_bus.m_awvalid && axi_bus.m_arvalid;
  assign rdy_ok  = reset_n && !stall;
  assign last    = (cnt_q == len_q);
  assign idx_nxt = (burst_q == AXI_BURST_FIXED) ? idx_q : idx_q + IDXW'(1);

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    burst_d  = burst_q;
    aw_rdy   = 1'b0;
    ar_rdy   = 1'b0;
    w_rdy    = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = idx_q;
    unique case (state_q)
      IDLE: begin
        aw_rdy = rdy_ok && !(both && rr_q == RR_READ);
        ar_rdy = rdy_ok && !(both && rr_q == RR_WRITE);
        if (axi_bus.m_awvalid && aw_rdy) begin
          idx_d   = axi_bus.m_awaddr[OFS +: IDXW];
          len_d   = axi_bus.m_awlen;
          burst_d = axi_bus.m_awburst;
          cnt_d   = '0;
          state_d = WRITE_BURST;
          if (both) rr_d = RR_READ;
        end else if (axi_bus.m_arvalid && ar_rdy) begin
          idx_d    = axi_bus.m_araddr[OFS +: IDXW];
          len_d    = axi_bus.m_arlen;
          burst_d  = axi_bus.m_arburst;
          cnt_d    = '0;
          mem_re   = 1'b1;
          mem_addr = axi_bus.m_araddr[OFS +: IDXW];
          state_d  = READ_BURST;
          if (both) rr_d = RR_WRITE;
        end
      end
      WRITE_BURST: begin
        w_rdy = rdy_ok;
        if (axi_bus.m_wvalid && w_rdy) begin
          mem_we = 1'b1;
          idx_d  = idx_nxt;
          if (last) state_d = WRITE_RESP;
          else      cnt_d   = cnt_q + 8'd1;
        end
      end
      WRITE_RESP: begin
        if (axi_bus.m_bready) state_d = IDLE;
      end
      READ_BURST: begin
        // Prefetch the next word on each accepted beat so data streams at one beat per cycle.
        if (axi_bus.m_rready) begin
          if (last) begin
            state_d = IDLE;
          end else begin
            idx_d    = idx_nxt;
            mem_re   = 1'b1;
            mem_addr = idx_nxt;
            cnt_d    = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= RR_WRITE;
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      burst_q <= AXI_BURST_INCR;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      burst_q <= burst_d;
    end
  end

  sram_1r1w_be #(.DEPTH(MEM_WORDS), .WIDTH(AXI_DATA_WIDTH)) u_sram (
    .clk     (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (mem_addr),
    .wdata_i (axi_bus.m_wdata),
    .be_i    (axi_bus.m_wstrb),
    .rdata_o (mem_q)
  );

  assign axi_bus.s_awready = aw_rdy;
  assign axi_bus.s_arready = ar_rdy;
  assign axi_bus.s_wready  = w_rdy;
  assign axi_bus.s_bvalid  = (state_q == WRITE_RESP);
  assign axi_bus.s_rvalid  = (state_q == READ_BURST);
  assign axi_bus.s_rdata   = (state_q == READ_BURST) ? mem_q : '0;

`ifndef SYNTHESIS
  wlast_matches_count: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == WRITE_BURST && axi_bus.m_wvalid && w_rdy) |-> (axi_bus.m_wlast == last));
`endif
endmodule

// File: tb/tb_axi_sram_responder.sv
// Randomized bench for axi_sram_responder against a word-array memory model.
module tb_axi_sram_responder;
  import axi_sram_responder_pkg::*;

  localparam int MW  = 256;
  localparam int TMO = 50;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  axi4_interface bus ();
  axi_sram_responder #(.MEM_WORDS(MW)) dut (.clk(clk), .reset_n(reset_n), .axi_bus(bus));

  logic [31:0] ref_mem [MW];
  bit          rr_rd;
  logic [31:0] wq [$];
  logic [3:0]  sq [$];
  int          n_chk, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a >> 2) % MW;
  endfunction

  // Called just after a negedge; returns just after the posedge that completed the handshake.
  task automatic wait_rdy(input int ch, input string tag);
    logic r;
    int   n = 0;
    forever begin
      #1;
      case (ch)
        0:       r = bus.s_awready;
        1:       r = bus.s_wready;
        default: r = bus.s_arready;
      endcase
      @(posedge clk);
      if (r) return;
      n++;
      if (n > TMO) begin
        chk({tag, "_timeout"}, 32'd0, 32'd1);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic fill(input int len, input bit full);
    wq.delete(); sq.delete();
    for (int k = 0; k <= len; k++) begin
      wq.push_back($urandom);
      sq.push_back(full ? 4'hF : 4'($urandom));
    end
  endtask

  task automatic drive_aw(input logic [31:0] a, input int len, input axi_burst_type_t bt);
    bus.m_awvalid = 1'b1; bus.m_awaddr = a; bus.m_awlen = 8'(len); bus.m_awburst = bt;
    bus.m_awsize = 3'($urandom); bus.m_awcache = 4'($urandom);
  endtask

  task automatic drive_ar(input logic [31:0] a, input int len, input axi_burst_type_t bt);
    bus.m_arvalid = 1'b1; bus.m_araddr = a; bus.m_arlen = 8'(len); bus.m_arburst = bt;
    bus.m_arsize = 3'($urandom); bus.m_arcache = 4'($urandom);
  endtask

  task automatic w_and_b(input logic [31:0] a, input int len, input axi_burst_type_t bt);
    int idx = widx(a);
    int g;
    logic [31:0] d;
    logic [3:0]  s;
    @(negedge clk); bus.m_awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      repeat (g) begin
        bus.m_wvalid = 1'b0;
        chk("bvalid_early", bus.s_bvalid, 0);
        @(negedge clk);
      end
      d = wq[k]; s = sq[k];
      bus.m_wvalid = 1'b1; bus.m_wdata = d; bus.m_wstrb = s; bus.m_wlast = (k == len);
      wait_rdy(1, "w");
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
      if (bt != AXI_BURST_FIXED) idx = (idx + 1) % MW;
      @(negedge clk);
    end
    bus.m_wvalid = 1'b0; bus.m_wlast = 1'b0;
    chk("bvalid_rise", bus.s_bvalid, 1);
    g = $urandom_range(0, 2);
    repeat (g) begin
      @(negedge clk);
      chk("bvalid_hold", bus.s_bvalid, 1);
    end
    bus.m_bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.m_bready = 1'b0;
    chk("bvalid_fall", bus.s_bvalid, 0);
  endtask

  task automatic r_beats(input logic [31:0] a, input int len, input axi_burst_type_t bt,
                         input int stall_at);
    int idx = widx(a);
    int g;
    @(negedge clk); bus.m_arvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if (k == stall_at) g = 3;
      else g = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      repeat (g) begin
        bus.m_rready = 1'b0;
        chk("rvalid_stall", bus.s_rvalid, 1);
        chk("rdata_stall", bus.s_rdata, ref_mem[idx]);
        @(negedge clk);
      end
      bus.m_rready = 1'b1;
      chk("rvalid", bus.s_rvalid, 1);
      chk("rdata", bus.s_rdata, ref_mem[idx]);
      if (bt != AXI_BURST_FIXED) idx = (idx + 1) % MW;
      @(negedge clk);
    end
    bus.m_rready = 1'b0;
    chk("rvalid_fall", bus.s_rvalid, 0);
  endtask

  task automatic do_write(input logic [31:0] a, input int len, input axi_burst_type_t bt);
    @(negedge clk);
    drive_aw(a, len, bt);
    wait_rdy(0, "aw");
    w_and_b(a, len, bt);
  endtask

  task automatic do_read(input logic [31:0] a, input int len, input axi_burst_type_t bt,
                         input int stall_at);
    @(negedge clk);
    drive_ar(a, len, bt);
    wait_rdy(2, "ar");
    r_beats(a, len, bt, stall_at);
  endtask

  // Both address channels raised together; arbitration order comes from the model pointer.
  task automatic contested(input logic [31:0] wa, input int wl, input axi_burst_type_t wb,
                           input logic [31:0] ra, input int rl, input axi_burst_type_t rb);
    @(negedge clk);
    drive_aw(wa, wl, wb);
    drive_ar(ra, rl, rb);
    #1;
    chk("arb_awready", bus.s_awready, !rr_rd);
    chk("arb_arready", bus.s_arready, rr_rd);
    if (!rr_rd) begin
      wait_rdy(0, "aw_arb"); rr_rd = 1'b1;
      w_and_b(wa, wl, wb);
      wait_rdy(2, "ar_after");
      r_beats(ra, rl, rb, -1);
    end else begin
      wait_rdy(2, "ar_arb"); rr_rd = 1'b0;
      r_beats(ra, rl, rb, -1);
      wait_rdy(0, "aw_after");
      w_and_b(wa, wl, wb);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_awready"}, bus.s_awready, 0);
    chk({tag, "_arready"}, bus.s_arready, 0);
    chk({tag, "_wready"},  bus.s_wready,  0);
    chk({tag, "_bvalid"},  bus.s_bvalid,  0);
    chk({tag, "_rvalid"},  bus.s_rvalid,  0);
    chk({tag, "_rdata"},   bus.s_rdata,   0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          len;
    axi_burst_type_t bt;
    n_chk = 0; n_err = 0; rr_rd = 1'b0;
    reset_n = 1'b0;
    bus.m_awvalid = 0; bus.m_awaddr = 0; bus.m_awlen = 0; bus.m_awsize = 0;
    bus.m_awburst = AXI_BURST_INCR; bus.m_awcache = 0;
    bus.m_wvalid = 0; bus.m_wdata = 0; bus.m_wstrb = 0; bus.m_wlast = 0; bus.m_bready = 0;
    bus.m_arvalid = 0; bus.m_araddr = 0; bus.m_arlen = 0; bus.m_arsize = 0;
    bus.m_arburst = AXI_BURST_INCR; bus.m_arcache = 0; bus.m_rready = 0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    #1;
    chk("idle_awready", bus.s_awready, 1);
    chk("idle_arready", bus.s_arready, 1);

    // Arbitration from reset: write first, then read; second time read first.
    fill(3, 1'b1);
    contested(32'h40, 3, AXI_BURST_INCR, 32'h40, 3, AXI_BURST_INCR);
    fill(3, 1'b1);
    contested(32'h80, 3, AXI_BURST_INCR, 32'h40, 3, AXI_BURST_INCR);

    fill(MW - 1, 1'b1);
    do_write(32'h0, MW - 1, AXI_BURST_INCR);

    // INCR write/read of A0..A3
    wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3}; sq = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(32'h100, 3, AXI_BURST_INCR);
    do_read(32'h100, 3, AXI_BURST_INCR, -1);

    // Byte strobes
    wq = '{32'hFFFF_FFFF}; sq = '{4'hF};
    do_write(32'h200, 0, AXI_BURST_INCR);
    wq = '{32'h1234_5678}; sq = '{4'b0101};
    do_write(32'h200, 0, AXI_BURST_INCR);
    do_read(32'h200, 0, AXI_BURST_INCR, -1);

    // FIXED burst lands on one word
    wq = '{32'd1, 32'd2, 32'd3}; sq = '{4'hF, 4'hF, 4'hF};
    do_write(32'h180, 2, AXI_BURST_FIXED);
    do_read(32'h17C, 3, AXI_BURST_INCR, -1);

    // Backpressure mid-burst, index wrap and address aliasing
    do_read(32'h100, 7, AXI_BURST_INCR, 3);
    fill(1, 1'b1);
    do_write(32'((MW - 1) * 4), 1, AXI_BURST_INCR);
    do_read(32'((MW - 1) * 4), 1, AXI_BURST_INCR, -1);
    do_read(32'((MW - 1) * 4 + MW * 4 * 5), 2, AXI_BURST_WRAP, -1);

    // Reset during beat 2 of an 8-beat write: only beats 0 and 1 land, no response.
    fill(7, 1'b1);
    @(negedge clk);
    drive_aw(32'h300, 7, AXI_BURST_INCR);
    wait_rdy(0, "aw_rst");
    @(negedge clk); bus.m_awvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.m_wvalid = 1'b1; bus.m_wdata = wq[k]; bus.m_wstrb = 4'hF; bus.m_wlast = 1'b0;
      wait_rdy(1, "w_rst");
      ref_mem[widx(32'h300) + k] = wq[k];
      @(negedge clk);
    end
    bus.m_wvalid = 1'b1; bus.m_wdata = wq[2];
    reset_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_outputs_zero("midreset");
    reset_n = 1'b1; bus.m_wvalid = 1'b0; bus.m_bready = 1'b1;
    rr_rd = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("no_bvalid", bus.s_bvalid, 0);
    end
    bus.m_bready = 1'b0;
    #1;
    chk("post_rst_awready", bus.s_awready, 1);
    chk("post_rst_arready", bus.s_arready, 1);
    do_read(32'h300, 7, AXI_BURST_INCR, -1);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      a   = $urandom;
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 20) : $urandom_range(0, 7);
      bt  = axi_burst_type_t'($urandom_range(0, 2));
      case ($urandom_range(0, 2))
        0: begin fill(len, 1'b0); do_write(a, len, bt); end
        1: do_read(a, len, bt, -1);
        default: begin
          fill(len, 1'b0);
          contested(a, len, bt, $urandom, $urandom_range(0, 7),
                    axi_burst_type_t'($urandom_range(0, 2)));
        end
      endcase
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
